// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the register file with its hazard scoreboard.
package reg_file_sb_pkg;
  localparam int RF_N        = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DEPTH    = 1 << RF_ADDR_W;
  localparam int RF_ZERO_IDX = 0;

  // pending_cnt must hold DEPTH itself, hence one bit more than the index.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits, pending count and sticky writeback error.
// Priority per edge: flush, then writeback clear, then issue set.
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int CNT_W    = cnt_width(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic              RegWrite,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              wb_err
);
  logic [DEPTH-1:0] r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_wr_zero, w_iss_zero, w_rd1_zero, w_rd2_zero;
  logic             w_wr_en, w_iss_en, w_inc, w_dec;
  logic [DEPTH-1:0] w_busy_nxt;

  always_comb begin
    w_wr_zero  = ZERO_REG && (write_reg == ADDR_W'(RF_ZERO_IDX));
    w_iss_zero = ZERO_REG && (issue_reg == ADDR_W'(RF_ZERO_IDX));
    w_wr_en    = RegWrite && !w_wr_zero;
    w_iss_en   = issue_valid && !flush && !w_iss_zero;
    // A same-register clear plus re-issue leaves the count untouched.
    w_inc      = w_iss_en && !r_busy[issue_reg];
    w_dec      = w_wr_en && r_busy[write_reg] && !(w_iss_en && (issue_reg == write_reg));
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr_en)  w_busy_nxt[write_reg] = 1'b0;
      if (w_iss_en) w_busy_nxt[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) r_cnt <= '0;
      else       r_cnt <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
      if (w_wr_en && !r_busy[write_reg]) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_rd1_zero = ZERO_REG && (read_reg1 == ADDR_W'(RF_ZERO_IDX));
    w_rd2_zero = ZERO_REG && (read_reg2 == ADDR_W'(RF_ZERO_IDX));
    busy1 = r_busy[read_reg1] && !w_rd1_zero && !(BYPASS && RegWrite && (write_reg == read_reg1));
    busy2 = r_busy[read_reg2] && !w_rd2_zero && !(BYPASS && RegWrite && (write_reg == read_reg2));
  end

  assign pending_cnt = r_cnt;
  assign wb_err      = r_err;
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-first bypass, zero register
// and a busy scoreboard feeding the hazard unit.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int N        = RF_N,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            read_reg1,
  input  logic [ADDR_W-1:0]            read_reg2,
  output logic [N-1:0]                 read_data1,
  output logic [N-1:0]                 read_data2,
  output logic                         busy1,
  output logic                         busy2,
  input  logic [ADDR_W-1:0]            write_reg,
  input  logic [N-1:0]                 write_data,
  input  logic                         RegWrite,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_reg,
  input  logic                         flush,
  output logic [cnt_width(ADDR_W)-1:0] pending_cnt,
  output logic                         wb_err
);
  logic [N-1:0] r_regs [DEPTH];
  logic         w_wr_en, w_rd1_zero, w_rd2_zero, w_fwd1, w_fwd2;

  always_comb begin
    w_wr_en    = RegWrite && !(ZERO_REG && (write_reg == ADDR_W'(RF_ZERO_IDX)));
    w_rd1_zero = ZERO_REG && (read_reg1 == ADDR_W'(RF_ZERO_IDX));
    w_rd2_zero = ZERO_REG && (read_reg2 == ADDR_W'(RF_ZERO_IDX));
    w_fwd1     = BYPASS && w_wr_en && (write_reg == read_reg1);
    w_fwd2     = BYPASS && w_wr_en && (write_reg == read_reg2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    if (w_rd1_zero)  read_data1 = '0;
    else if (w_fwd1) read_data1 = write_data;
    else             read_data1 = r_regs[read_reg1];
    if (w_rd2_zero)  read_data2 = '0;
    else if (w_fwd2) read_data2 = write_data;
    else             read_data2 = r_regs[read_reg2];
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .write_reg   (write_reg),
    .RegWrite    (RegWrite),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .flush       (flush),
    .busy1       (busy1),
    .busy2       (busy2),
    .pending_cnt (pending_cnt),
    .wb_err      (wb_err)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations queued by the driver, checked by a negedge monitor.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  read_reg1 = '0, read_reg2 = '0, write_reg = '0, issue_reg = '0;
  logic [31:0] write_data = '0;
  logic        RegWrite = 1'b0, issue_valid = 1'b0, flush = 1'b0;
  logic [31:0] read_data1, read_data2;
  logic        busy1, busy2, wb_err;
  logic [5:0]  pending_cnt;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .busy1(busy1), .busy2(busy2),
    .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .flush(flush),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // Reference state: plain arrays, count derived by counting busy entries.
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  bit          m_err;

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (RegWrite && write_reg == r) return write_data;
    return m_reg[r];
  endfunction

  function automatic logic m_busy_out(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (RegWrite && write_reg == r) return 1'b0;
    return m_busy[r];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.rd1 = m_read(read_reg1);
    e.rd2 = m_read(read_reg2);
    e.b1  = m_busy_out(read_reg1);
    e.b2  = m_busy_out(read_reg2);
    e.cnt = 6'(m_pending());
    e.err = m_err;
    e.cyc = 32'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic m_edge();
    if (RegWrite && write_reg != 0) begin
      if (!m_busy[write_reg]) m_err = 1'b1;
      m_reg[write_reg] = write_data;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (RegWrite && write_reg != 0) m_busy[write_reg] = 1'b0;
      if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
    end
  endtask

  // Called at posedge+1: apply inputs, queue expected outputs, advance one edge.
  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ir, input logic fl);
    read_reg1 = r1; read_reg2 = r2;
    RegWrite = we; write_reg = wr; write_data = wd;
    issue_valid = iv; issue_reg = ir; flush = fl;
    push_exp();
    @(posedge clk);
    m_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(r1, r2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want,
                     input logic [31:0] c);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("read_data1", read_data1, e.rd1, e.cyc);
      chk("read_data2", read_data2, e.rd2, e.cyc);
      chk("busy1", 32'(busy1), 32'(e.b1), e.cyc);
      chk("busy2", 32'(busy2), 32'(e.b2), e.cyc);
      chk("pending_cnt", 32'(pending_cnt), 32'(e.cnt), e.cyc);
      chk("wb_err", 32'(wb_err), 32'(e.err), e.cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;

    idle(5'd5, 5'd7);                                           // reset state
    // issue 7, then write it back with bypass
    drive(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    idle(5'd7, 5'd3);
    drive(5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0);
    idle(5'd7, 5'd0);
    // same-edge writeback and re-issue of reg 9
    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    drive(5'd9, 5'd1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 1'b0);
    idle(5'd9, 5'd9);
    drive(5'd9, 5'd2, 1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 1'b0);
    // zero register ignores writes and issue
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
    drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    idle(5'd0, 5'd0);
    // fill the scoreboard, then flush with a dropped issue
    for (int i = 1; i < 32; i++)
      drive(5'(i), 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b0);
    idle(5'd31, 5'd4);
    drive(5'd4, 5'd31, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1);
    idle(5'd4, 5'd31);
    // writeback to a non-busy register sets the sticky error
    drive(5'd12, 5'd0, 1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 1'b0);
    idle(5'd12, 5'd12);
    drive(5'd12, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    idle(5'd12, 5'd3);
    // build pending=3 and reg5, then reset asynchronously mid-cycle
    drive(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    drive(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    drive(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    drive(5'd5, 5'd1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    idle(5'd5, 5'd1);
    read_reg1 = 5'd5; read_reg2 = 5'd2;
    RegWrite = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    m_reset();
    #1 push_exp();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); cyc++; #1;
    idle(5'd5, 5'd1);

    // randomized traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r1, r2, wr, ir;
      r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      wr = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 7));
      ir = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 7));
      drive(r1, r2, 1'($urandom_range(0, 1)), wr, $urandom,
            1'($urandom_range(0, 1)), ir, $urandom_range(0, 24) == 0);
    end
    idle(5'd1, 5'd2);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with two combinational read ports and one write port.
- Adds write-first bypass, optional hard-wired zero register, and a per-register busy scoreboard for the pipeline's hazard unit.
- The decode stage reads operands and busy flags. Issue marks the destination busy. Writeback writes the data and clears busy.
- A pending-register counter and a sticky writeback-error flag support debug.

Parameters:
- N, 32: data width.
- ADDR_W, 5: register index width.
- DEPTH, 1<<ADDR_W: number of registers.
- ZERO_REG, 1: when 1, register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1: when 1, same-cycle writeback data and busy-clear are forwarded to the read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- read_reg1  in  ADDR_W  read port 1 index.
- read_reg2  in  ADDR_W  read port 2 index.
- read_data1  out  N  read port 1 data.
- read_data2  out  N  read port 2 data.
- busy1  out  1  scoreboard bit for read_reg1.
- busy2  out  1  scoreboard bit for read_reg2.
- write_reg  in  ADDR_W  writeback index.
- write_data  in  N  writeback data.
- RegWrite  in  1  writeback enable; also clears busy for write_reg.
- issue_valid  in  1  allocate a destination.
- issue_reg  in  ADDR_W  destination index to mark busy.
- flush  in  1  clear all busy bits (pipeline flush).
- pending_cnt  out  ADDR_W+1  number of busy registers.
- wb_err  out  1  sticky flag: writeback to a non-busy register.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - all registers = 0, all busy bits = 0;
  - pending_cnt = 0, wb_err = 0.
  - The outputs follow immediately: read_data = 0, busy = 0.
- Write: at the rising edge, if RegWrite and !(ZERO_REG && write_reg==0), then reg[write_reg] <= write_data. Any index below DEPTH is legal.
- Read: combinational.
  - read_dataX = reg[read_regX].
  - If ZERO_REG and read_regX==0, read_dataX = 0.
  - If BYPASS and RegWrite and write_reg==read_regX (and not the zero register), read_dataX = write_data (write-first).
- busyX: busy[read_regX], forced to 0 when either:
  - ZERO_REG and index 0; or
  - BYPASS and RegWrite and write_reg==read_regX (the clear is forwarded).
- Scoreboard update per edge, priority in this order:
  1. flush: all busy <= 0 and pending_cnt <= 0. Any same-cycle issue is dropped. The same-cycle write still happens.
  2. Writeback clear: RegWrite clears busy[write_reg].
  3. Issue set: issue_valid sets busy[issue_reg]; this overrides the clear when issue_reg==write_reg. The busy bit stays 1 and the new producer wins.
  - Issue to register 0 with ZERO_REG=1 is ignored.
  - Issue to an already-busy register leaves it busy and does not count it twice.
- pending_cnt must equal the popcount of the busy bits after every edge. It is updated incrementally:
  - +1 when a non-busy register becomes busy;
  - −1 when a busy register is cleared and not re-issued;
  - net 0 for both events on different registers, or for a same-register clear plus re-issue.
  - It can never exceed DEPTH (DEPTH−1 when ZERO_REG=1) and never wraps.
- wb_err is set at the edge when RegWrite targets a register whose busy bit is 0, excluding register 0 when ZERO_REG=1. The data is still written. Only rst clears wb_err; flush does not.
- Latency:
  - data written at edge k is visible on the read ports from cycle k+1, or in cycle k via bypass;
  - issue at edge k makes busyX = 1 from cycle k+1.

Decomposition:
- Shared package/header: ADDR_W, DEPTH, the zero-register index constant, and the pending_cnt width expression.
- One natural sub-module: rf_scoreboard, which holds the busy bits, pending_cnt, wb_err and the set/clear/flush priority.
- Data storage, bypass muxes and zero-forcing stay in the top module.

Test Plan:
- Reset while pending_cnt=3 and reg[5]=0xDEADBEEF, asserted asynchronously mid-cycle:
  - all read_data = 0, busy = 0, pending_cnt = 0 and wb_err = 0 before the next edge.
- Issue reg 7 at edge 1, then RegWrite reg 7 = 0x12345678 at edge 3 with read_reg1=7:
  - busy1 = 1 in cycle 2;
  - in cycle 3, read_data1 = 0x12345678 and busy1 = 0 (bypass);
  - pending_cnt goes 0→1→0.
- Same edge: issue reg 9 and RegWrite reg 9 = 0xA5A5A5A5, reg 9 previously busy:
  - reg[9] = 0xA5A5A5A5, busy[9] stays 1, pending_cnt unchanged.
- Register 0 with ZERO_REG=1:
  - RegWrite reg 0 = 0xFFFFFFFF, then issue reg 0 → read_data1 = 0, busy1 = 0, pending_cnt = 0, wb_err = 0.
- Issue regs 1..31 on successive edges, then flush together with issue reg 4:
  - pending_cnt reaches 31, then becomes 0;
  - busy[4] = 0 after the flush.
- RegWrite reg 12 = 0x55 while reg 12 is not busy:
  - reg[12] = 0x55, wb_err = 1;
  - wb_err stays 1 after a subsequent flush and clears only on rst.
